// File: rtl/dm_bus_arbiter.sv
// Shares one system-bus master port between the DM SBA engine (port 0) and an
// auxiliary master (port 1). Round-robin arbitration, one transaction in flight,
// response routed back to the owning port, timeout turns a missing response into
// an error response.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no transaction; grant issued combinationally to the winner
// REQ    | bus_req_o asserted with latched attributes, waiting for bus_gnt_i
// RESP   | waiting for bus_r_valid_i; timeout counter running
module dm_bus_arbiter #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   dmactive_i,

    input  logic                   m0_req_i,
    input  logic [AddrWidth-1:0]   m0_add_i,
    input  logic                   m0_we_i,
    input  logic [DataWidth-1:0]   m0_wdata_i,
    input  logic [DataWidth/8-1:0] m0_be_i,
    output logic                   m0_gnt_o,
    output logic                   m0_r_valid_o,
    output logic                   m0_r_err_o,
    output logic [DataWidth-1:0]   m0_r_rdata_o,

    input  logic                   m1_req_i,
    input  logic [AddrWidth-1:0]   m1_add_i,
    input  logic                   m1_we_i,
    input  logic [DataWidth-1:0]   m1_wdata_i,
    input  logic [DataWidth/8-1:0] m1_be_i,
    output logic                   m1_gnt_o,
    output logic                   m1_r_valid_o,
    output logic                   m1_r_err_o,
    output logic [DataWidth-1:0]   m1_r_rdata_o,

    output logic                   bus_req_o,
    output logic [AddrWidth-1:0]   bus_add_o,
    output logic                   bus_we_o,
    output logic [DataWidth-1:0]   bus_wdata_o,
    output logic [DataWidth/8-1:0] bus_be_o,
    input  logic                   bus_gnt_i,
    input  logic                   bus_r_valid_i,
    input  logic                   bus_r_err_i,
    input  logic [DataWidth-1:0]   bus_r_rdata_i
);

    localparam int BeWidth  = DataWidth / 8;
    localparam int CntWidth = $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                state_q;
    logic                  owner_q;
    logic                  last_q;
    logic [CntWidth-1:0]   cnt_q;
    logic [AddrWidth-1:0]  add_q;
    logic                  we_q;
    logic [DataWidth-1:0]  wdata_q;
    logic [BeWidth-1:0]    be_q;

    logic                  eff0;
    logic                  eff1;
    logic                  winner;
    logic                  grant;
    logic                  in_resp;
    logic                  done;
    logic                  resp_err;
    logic [DataWidth-1:0]  resp_data;

    // Arbitration, response forwarding and timeout detection. Gated by rst_ni so a
    // cycle held in reset neither captures a request nor delivers a response.
    always_comb begin
        eff0      = m0_req_i & dmactive_i;
        eff1      = m1_req_i;
        winner    = (eff0 & eff1) ? ~last_q : eff1;
        grant     = rst_ni & (state_q == ST_IDLE) & (eff0 | eff1);
        in_resp   = rst_ni & (state_q == ST_RESP);
        // A real response in the timeout cycle takes precedence over the timeout.
        done      = in_resp & (bus_r_valid_i | (cnt_q == CntLast));
        resp_err  = bus_r_valid_i ? bus_r_err_i : 1'b1;
        resp_data = bus_r_valid_i ? bus_r_rdata_i : '0;

        m0_gnt_o     = grant & ~winner;
        m1_gnt_o     = grant & winner;
        m0_r_valid_o = done & ~owner_q;
        m1_r_valid_o = done & owner_q;
        m0_r_err_o   = done & ~owner_q & resp_err;
        m1_r_err_o   = done & owner_q & resp_err;
        m0_r_rdata_o = (done & ~owner_q) ? resp_data : '0;
        m1_r_rdata_o = (done & owner_q) ? resp_data : '0;

        bus_req_o   = (state_q == ST_REQ);
        bus_add_o   = add_q;
        bus_we_o    = we_q;
        bus_wdata_o = wdata_q;
        bus_be_o    = be_q;
    end

    // Transaction sequencing: capture on grant, hand off to the bus, wait for the
    // response. last_q moves on any completion (including timeout) so a port whose
    // target hangs cannot starve the other.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            add_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (eff0 | eff1) begin
                        owner_q <= winner;
                        add_q   <= winner ? m1_add_i   : m0_add_i;
                        we_q    <= winner ? m1_we_i    : m0_we_i;
                        wdata_q <= winner ? m1_wdata_i : m0_wdata_i;
                        be_q    <= winner ? m1_be_i    : m0_be_i;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus_gnt_i) begin
                        cnt_q   <= '0;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (done) begin
                        last_q  <= owner_q;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CntWidth'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Bench for dm_bus_arbiter: directed scenarios with literal expectations, then
// randomized traffic, all continuously checked against a transaction-level model.
module tb_dm_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dmactive;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_add, m0_wdata, m1_add, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_gnt_o, m0_r_valid_o, m0_r_err_o;
    logic        m1_gnt_o, m1_r_valid_o, m1_r_err_o;
    logic [31:0] m0_r_rdata_o, m1_r_rdata_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_add_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i, bus_r_valid_i, bus_r_err_i;
    logic [31:0] bus_r_rdata_i;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dm_bus_arbiter #(.AddrWidth(32), .DataWidth(32), .TimeoutCycles(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive),
        .m0_req_i(m0_req), .m0_add_i(m0_add), .m0_we_i(m0_we), .m0_wdata_i(m0_wdata),
        .m0_be_i(m0_be), .m0_gnt_o(m0_gnt_o), .m0_r_valid_o(m0_r_valid_o),
        .m0_r_err_o(m0_r_err_o), .m0_r_rdata_o(m0_r_rdata_o),
        .m1_req_i(m1_req), .m1_add_i(m1_add), .m1_we_i(m1_we), .m1_wdata_i(m1_wdata),
        .m1_be_i(m1_be), .m1_gnt_o(m1_gnt_o), .m1_r_valid_o(m1_r_valid_o),
        .m1_r_err_o(m1_r_err_o), .m1_r_rdata_o(m1_r_rdata_o),
        .bus_req_o(bus_req_o), .bus_add_o(bus_add_o), .bus_we_o(bus_we_o),
        .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .bus_gnt_i(bus_gnt_i),
        .bus_r_valid_i(bus_r_valid_i), .bus_r_err_i(bus_r_err_i),
        .bus_r_rdata_i(bus_r_rdata_i)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs only ever change 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level reference model ----------------
    bit          md_busy  = 0;
    bit          md_acc   = 0;
    int          md_owner = 0;
    int          md_age   = 0;
    int          md_last  = 1;
    logic [31:0] ma_add   = '0;
    logic [31:0] ma_wdata = '0;
    logic        ma_we    = 1'b0;
    logic [3:0]  ma_be    = '0;

    always @(negedge clk) begin : model
        bit          e0, e1, gok, fire, e_err;
        int          w;
        logic [31:0] e_data;
        e0  = m0_req && dmactive;
        e1  = m1_req;
        w   = (e0 && e1) ? 1 - md_last : (e1 ? 1 : 0);
        gok = rst_n && !md_busy && (e0 || e1);
        chk("m0_gnt", m0_gnt_o, gok && w == 0);
        chk("m1_gnt", m1_gnt_o, gok && w == 1);
        chk("bus_req", bus_req_o, md_busy && !md_acc);
        chk("bus_add", bus_add_o, ma_add);
        chk("bus_we", bus_we_o, ma_we);
        chk("bus_wdata", bus_wdata_o, ma_wdata);
        chk("bus_be", bus_be_o, ma_be);
        fire   = rst_n && md_busy && md_acc && (bus_r_valid_i || md_age == TO - 1);
        e_err  = bus_r_valid_i ? bus_r_err_i : 1'b1;
        e_data = bus_r_valid_i ? bus_r_rdata_i : 32'h0;
        chk("m0_r_valid", m0_r_valid_o, fire && md_owner == 0);
        chk("m1_r_valid", m1_r_valid_o, fire && md_owner == 1);
        chk("m0_r_err", m0_r_err_o, fire && md_owner == 0 && e_err);
        chk("m1_r_err", m1_r_err_o, fire && md_owner == 1 && e_err);
        chk("m0_r_rdata", m0_r_rdata_o, (fire && md_owner == 0) ? e_data : 32'h0);
        chk("m1_r_rdata", m1_r_rdata_o, (fire && md_owner == 1) ? e_data : 32'h0);

        if (!rst_n) begin
            md_busy = 0; md_acc = 0; md_owner = 0; md_age = 0; md_last = 1;
            ma_add = '0; ma_wdata = '0; ma_we = 1'b0; ma_be = '0;
        end else if (!md_busy) begin
            if (e0 || e1) begin
                md_busy  = 1;
                md_acc   = 0;
                md_owner = w;
                ma_add   = (w == 1) ? m1_add   : m0_add;
                ma_we    = (w == 1) ? m1_we    : m0_we;
                ma_wdata = (w == 1) ? m1_wdata : m0_wdata;
                ma_be    = (w == 1) ? m1_be    : m0_be;
            end
        end else if (!md_acc) begin
            if (bus_gnt_i) begin
                md_acc = 1;
                md_age = 0;
            end
        end else if (fire) begin
            md_busy = 0;
            md_last = md_owner;
        end else begin
            md_age++;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic clear_inputs();
        dmactive = 1'b1;
        m0_req = 0; m0_we = 0; m0_add = '0; m0_wdata = '0; m0_be = '0;
        m1_req = 0; m1_we = 0; m1_add = '0; m1_wdata = '0; m1_be = '0;
        bus_gnt_i = 0; bus_r_valid_i = 0; bus_r_err_i = 0; bus_r_rdata_i = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    // Returns at the start of the first REQ cycle with the granted port, or -1.
    task automatic wait_grant(output int w);
        w = -1;
        for (int i = 0; i < 16 && w < 0; i++) begin
            @(negedge clk);
            if (m0_gnt_o) w = 0;
            else if (m1_gnt_o) w = 1;
            step();
        end
        if (w < 0) begin
            total++;
            bad++;
            $display("FAIL grant_wait: got no grant expected a grant within 16 cycles");
        end
    endtask

    // Called at the start of a REQ cycle; bus grant after gd cycles, response rd
    // cycles into RESP (rd < TO-1).
    task automatic serve(input int gd, input int rd, input bit err,
                         input logic [31:0] data, input int own);
        for (int i = 0; i <= gd; i++) begin
            bus_gnt_i = (i == gd);
            @(negedge clk);
            chk("req_phase_bus_req", bus_req_o, 1);
            step();
        end
        bus_gnt_i = 0;
        for (int i = 0; i <= rd; i++) begin
            if (i == rd) begin
                bus_r_valid_i = 1; bus_r_err_i = err; bus_r_rdata_i = data;
            end
            @(negedge clk);
            chk("resp_bus_req_low", bus_req_o, 0);
            if (i == rd) begin
                chk("owner_r_valid", (own == 1) ? m1_r_valid_o : m0_r_valid_o, 1);
                chk("owner_r_err", (own == 1) ? m1_r_err_o : m0_r_err_o, err);
                chk("owner_r_rdata", (own == 1) ? m1_r_rdata_o : m0_r_rdata_o, data);
                chk("other_r_valid", (own == 1) ? m0_r_valid_o : m1_r_valid_o, 0);
            end else begin
                chk("early_r_valid", m0_r_valid_o | m1_r_valid_o, 0);
            end
            step();
        end
        bus_r_valid_i = 0; bus_r_err_i = 0; bus_r_rdata_i = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0;
        clear_inputs();
        do_reset();

        // reset state
        @(negedge clk);
        chk("rst_bus_req", bus_req_o, 0);
        chk("rst_bus_add", bus_add_o, 0);
        chk("rst_r_valid", m0_r_valid_o | m1_r_valid_o, 0);
        step();

        // 1: m0 read 0x1000, bus grant after 2 cycles, data 0xDEADBEEF
        m0_req = 1; m0_add = 32'h1000; m0_we = 0;
        wait_grant(w);
        chk("t1_grant_port", w, 0);
        m0_req = 0;
        @(negedge clk);
        chk("t1_bus_add", bus_add_o, 32'h1000);
        chk("t1_bus_we", bus_we_o, 0);
        step();
        serve(1, 0, 0, 32'hDEADBEEF, 0);

        // 2: both requesting continuously after reset -> 0,1,0,1
        do_reset();
        m0_req = 1; m0_add = 32'hA0; m1_req = 1; m1_add = 32'hB0;
        for (int k = 0; k < 4; k++) begin
            wait_grant(w);
            chk("t2_order", w, k % 2);
            @(negedge clk);
            chk("t2_bus_add", bus_add_o, (k % 2) ? 32'hB0 : 32'hA0);
            step();
            serve(0, k % 3, 0, 32'h100 + k, k % 2);
        end
        m0_req = 0; m1_req = 0;

        // 3: m1 write with error response
        m1_req = 1; m1_we = 1; m1_add = 32'h2000; m1_wdata = 32'h55AA55AA; m1_be = 4'b0011;
        wait_grant(w);
        chk("t3_grant_port", w, 1);
        m1_req = 0;
        @(negedge clk);
        chk("t3_bus_add", bus_add_o, 32'h2000);
        chk("t3_bus_we", bus_we_o, 1);
        chk("t3_bus_wdata", bus_wdata_o, 32'h55AA55AA);
        chk("t3_bus_be", bus_be_o, 4'b0011);
        step();
        serve(0, 1, 1, 32'h0, 1);

        // 4: bus never responds -> timeout error on 4th RESP cycle
        m0_req = 1; m0_we = 0; m0_add = 32'h3000;
        wait_grant(w);
        chk("t4_grant_port", w, 0);
        m0_req = 0;
        bus_gnt_i = 1;
        step();
        bus_gnt_i = 0; bus_r_err_i = 0; bus_r_rdata_i = 32'h12345678;
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            chk("t4_m0_r_valid", m0_r_valid_o, i == TO);
            if (i == TO) begin
                chk("t4_m0_r_err", m0_r_err_o, 1);
                chk("t4_m0_r_rdata", m0_r_rdata_o, 0);
            end
            step();
        end
        bus_r_valid_i = 1;
        @(negedge clk);
        chk("t4_late_ignored", m0_r_valid_o | m1_r_valid_o, 0);
        step();
        bus_r_valid_i = 0; bus_r_rdata_i = '0;
        m1_req = 1; m1_we = 0; m1_add = 32'h3004;
        wait_grant(w);
        chk("t4_next_grant", w, 1);
        m1_req = 0;
        serve(0, 0, 0, 32'hCAFE0001, 1);

        // 5: dmactive masks port 0
        dmactive = 0; m0_req = 1; m0_add = 32'h4000;
        repeat (3) begin
            @(negedge clk);
            chk("t5_m0_masked", m0_gnt_o, 0);
            step();
        end
        m1_req = 1; m1_add = 32'h4100;
        wait_grant(w);
        chk("t5_m1_grant", w, 1);
        m1_req = 0;
        serve(0, 0, 0, 32'h41, 1);
        dmactive = 1;
        wait_grant(w);
        chk("t5_m0_grant", w, 0);
        m0_req = 0;
        serve(0, 0, 0, 32'h40, 0);

        // 6: reset while in RESP
        m0_req = 1; m0_add = 32'h5000;
        wait_grant(w);
        m0_req = 0;
        bus_gnt_i = 1;
        step();
        bus_gnt_i = 0;
        rst_n = 0;
        @(negedge clk);
        chk("t6_no_resp_in_rst", m0_r_valid_o, 0);
        step();
        rst_n = 1; bus_r_valid_i = 1; bus_r_rdata_i = 32'h5;
        @(negedge clk);
        chk("t6_bus_req", bus_req_o, 0);
        chk("t6_r_valid", m0_r_valid_o | m1_r_valid_o, 0);
        chk("t6_bus_add", bus_add_o, 0);
        step();
        bus_r_valid_i = 0; bus_r_rdata_i = '0;
        m0_req = 1; m1_req = 1; m0_add = 32'h6000; m1_add = 32'h6100;
        wait_grant(w);
        chk("t6_tie_to_m0", w, 0);
        m0_req = 0; m1_req = 0;
        serve(0, 0, 0, 32'h60, 0);

        // randomized traffic, model checks every cycle
        for (int c = 0; c < 3000; c++) begin
            rst_n         = ($urandom_range(0, 199) != 0);
            dmactive      = ($urandom_range(0, 9) != 0);
            m0_req        = ($urandom_range(0, 1) == 1);
            m1_req        = ($urandom_range(0, 1) == 1);
            m0_add        = $urandom;  m1_add   = $urandom;
            m0_wdata      = $urandom;  m1_wdata = $urandom;
            m0_we         = $urandom_range(0, 1);
            m1_we         = $urandom_range(0, 1);
            m0_be         = 4'($urandom);
            m1_be         = 4'($urandom);
            bus_gnt_i     = ($urandom_range(0, 4) < 2);
            bus_r_valid_i = ($urandom_range(0, 3) == 0);
            bus_r_err_i   = $urandom_range(0, 1);
            bus_r_rdata_i = $urandom;
            step();
        end
        rst_n = 1;
        clear_inputs();
        step();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
